// File: rtl/quote_order_gen.sv
// rtl/quote_order_gen.sv - turns (buy, ask) price pairs into NEW/REPLACE/CANCEL order messages
module quote_order_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int QTY_WIDTH  = 16,
  parameter int ID_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_buy_price,
  input  logic [DATA_WIDTH-1:0] i_ask_price,
  input  logic                  i_data_valid,
  input  logic [QTY_WIDTH-1:0]  i_quantity,
  output logic                  o_order_valid,
  input  logic                  i_order_ready,
  output logic                  o_order_side,
  output logic [1:0]            o_order_type,
  output logic [DATA_WIDTH-1:0] o_order_price,
  output logic [QTY_WIDTH-1:0]  o_order_qty,
  output logic [ID_WIDTH-1:0]   o_order_id,
  output logic                  o_quote_dropped
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EVAL     = 2'd1;
  localparam logic [1:0] S_SEND_BID = 2'd2;
  localparam logic [1:0] S_SEND_ASK = 2'd3;

  localparam logic [1:0] T_NEW     = 2'd0;
  localparam logic [1:0] T_REPLACE = 2'd1;
  localparam logic [1:0] T_CANCEL  = 2'd2;

  logic [1:0]            state;
  logic                  pend_vld;
  logic [DATA_WIDTH-1:0] pend_buy, pend_ask;
  logic [DATA_WIDTH-1:0] work_buy, work_ask;
  logic                  bid_act, ask_act;
  logic [1:0]            bid_type, ask_type;
  logic [QTY_WIDTH-1:0]  qty_q;
  logic                  bid_active, ask_active;
  logic [DATA_WIDTH-1:0] bid_price, ask_price;
  logic [ID_WIDTH-1:0]   order_id;
  logic                  quote_dropped;

  logic                  consume, accept, pair_ok, send_ask, cur_cancel;
  logic [2:0]            bid_eval, ask_eval;
  logic [1:0]            cur_type;
  logic [ID_WIDTH-1:0]   next_id;

  // Returns {has_action, order_type} for one side of the working pair.
  function automatic logic [2:0] side_action(input logic ok, input logic active,
                                             input logic [DATA_WIDTH-1:0] live,
                                             input logic [DATA_WIDTH-1:0] px);
    if (ok && !active)      return {1'b1, T_NEW};
    if (ok && live != px)   return {1'b1, T_REPLACE};
    if (!ok && active)      return {1'b1, T_CANCEL};
    return {1'b0, T_NEW};
  endfunction

  assign consume    = (state == S_IDLE) && pend_vld;
  assign pair_ok    = (work_buy != '0) && (work_ask != '0) && (work_buy < work_ask);
  assign bid_eval   = side_action(pair_ok, bid_active, bid_price, work_buy);
  assign ask_eval   = side_action(pair_ok, ask_active, ask_price, work_ask);
  assign next_id    = (order_id == '1) ? ID_WIDTH'(1) : order_id + ID_WIDTH'(1);

  assign o_order_valid   = (state == S_SEND_BID) || (state == S_SEND_ASK);
  assign accept          = o_order_valid && i_order_ready;
  assign send_ask        = (state == S_SEND_ASK);
  assign cur_type        = send_ask ? ask_type : bid_type;
  assign cur_cancel      = (cur_type == T_CANCEL);
  assign o_order_side    = send_ask;
  assign o_order_type    = o_order_valid ? cur_type : 2'd0;
  assign o_order_price   = (o_order_valid && !cur_cancel) ? (send_ask ? work_ask : work_buy) : '0;
  assign o_order_qty     = (o_order_valid && !cur_cancel) ? qty_q : '0;
  assign o_order_id      = o_order_valid ? order_id : '0;
  assign o_quote_dropped = quote_dropped;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      pend_vld      <= 1'b0;
      pend_buy      <= '0;
      pend_ask      <= '0;
      work_buy      <= '0;
      work_ask      <= '0;
      bid_act       <= 1'b0;
      ask_act       <= 1'b0;
      bid_type      <= T_NEW;
      ask_type      <= T_NEW;
      qty_q         <= '0;
      bid_active    <= 1'b0;
      ask_active    <= 1'b0;
      bid_price     <= '0;
      ask_price     <= '0;
      order_id      <= ID_WIDTH'(1);
      quote_dropped <= 1'b0;
    end else begin
      // Latest-wins: an arrival always lands; only an unconsumed overwrite counts as a drop.
      quote_dropped <= i_data_valid && pend_vld && !consume;
      if (i_data_valid) begin
        pend_buy <= i_buy_price;
        pend_ask <= i_ask_price;
        pend_vld <= 1'b1;
      end else if (consume) begin
        pend_vld <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (pend_vld) begin
            work_buy <= pend_buy;
            work_ask <= pend_ask;
            state    <= S_EVAL;
          end
        end
        S_EVAL: begin
          bid_act  <= bid_eval[2];
          bid_type <= bid_eval[1:0];
          ask_act  <= ask_eval[2];
          ask_type <= ask_eval[1:0];
          qty_q    <= i_quantity;
          if (bid_eval[2])      state <= S_SEND_BID;
          else if (ask_eval[2]) state <= S_SEND_ASK;
          else                  state <= S_IDLE;
        end
        S_SEND_BID: begin
          if (accept) begin
            bid_active <= (bid_type != T_CANCEL);
            if (bid_type != T_CANCEL) bid_price <= work_buy;
            order_id   <= next_id;
            state      <= ask_act ? S_SEND_ASK : S_IDLE;
          end
        end
        S_SEND_ASK: begin
          if (accept) begin
            ask_active <= (ask_type != T_CANCEL);
            if (ask_type != T_CANCEL) ask_price <= work_ask;
            order_id   <= next_id;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quote_order_gen.sv
// tb/tb_quote_order_gen.sv - scoreboard bench for quote_order_gen
module tb_quote_order_gen;
  localparam int DW = 32;
  localparam int QW = 16;
  localparam int IW = 4;

  localparam logic [1:0] NEW = 2'd0;
  localparam logic [1:0] REP = 2'd1;
  localparam logic [1:0] CAN = 2'd2;

  typedef struct packed {
    logic          side;
    logic [1:0]    typ;
    logic [DW-1:0] price;
    logic [QW-1:0] qty;
    logic [IW-1:0] id;
  } ord_t;

  logic          clk = 1'b0;
  logic          i_reset;
  logic [DW-1:0] i_buy_price, i_ask_price;
  logic          i_data_valid;
  logic [QW-1:0] i_quantity;
  logic          o_order_valid;
  logic          i_order_ready;
  logic          o_order_side;
  logic [1:0]    o_order_type;
  logic [DW-1:0] o_order_price;
  logic [QW-1:0] o_order_qty;
  logic [IW-1:0] o_order_id;
  logic          o_quote_dropped;

  always #5 clk = ~clk;

  quote_order_gen #(.DATA_WIDTH(DW), .QTY_WIDTH(QW), .ID_WIDTH(IW)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_buy_price(i_buy_price), .i_ask_price(i_ask_price),
    .i_data_valid(i_data_valid), .i_quantity(i_quantity),
    .o_order_valid(o_order_valid), .i_order_ready(i_order_ready),
    .o_order_side(o_order_side), .o_order_type(o_order_type),
    .o_order_price(o_order_price), .o_order_qty(o_order_qty),
    .o_order_id(o_order_id), .o_quote_dropped(o_quote_dropped)
  );

  int checks = 0;
  int failures = 0;
  int drops = 0;
  int d0;
  logic [IW-1:0] exp_id;
  ord_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic s, input logic [1:0] t, input logic [DW-1:0] p, input logic [QW-1:0] q);
    ord_t o;
    o = {s, t, p, q, exp_id};
    exp_q.push_back(o);
    exp_id = (exp_id == '1) ? IW'(1) : exp_id + IW'(1);
  endtask

  task automatic send_pair(input logic [DW-1:0] b, input logic [DW-1:0] a);
    @(posedge clk); #1;
    i_buy_price = b; i_ask_price = a; i_data_valid = 1'b1;
    @(posedge clk); #1;
    i_data_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (10) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!o_order_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {63'd0, o_order_valid}, 64'd1);
  endtask

  task automatic check_zero(input string name);
    check(name, 64'({o_order_valid, o_order_side, o_order_type, o_order_price,
                     o_order_qty, o_order_id, o_quote_dropped}), 64'd0);
  endtask

  // Monitor: pops on every handshake, and checks fields hold while stalled.
  ord_t held, cur, e;
  logic held_vld = 1'b0;
  always @(negedge clk) begin
    if (i_reset) begin
      held_vld = 1'b0;
    end else begin
      if (o_quote_dropped) drops++;
      if (o_order_valid) begin
        cur = {o_order_side, o_order_type, o_order_price, o_order_qty, o_order_id};
        if (held_vld) check("stable", 64'(cur), 64'(held));
        if (i_order_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_order actual=%h expected=none", cur);
          end else begin
            e = exp_q.pop_front();
            check("order", 64'(cur), 64'(e));
          end
          held_vld = 1'b0;
        end else begin
          held = cur;
          held_vld = 1'b1;
        end
      end else begin
        held_vld = 1'b0;
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_buy_price = '0; i_ask_price = '0; i_data_valid = 1'b0;
    i_quantity = '0; i_order_ready = 1'b0;
    exp_id = IW'(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk); #1;
    i_reset = 1'b0;

    // First pair: NEW both sides, with latency checked cycle by cycle.
    i_order_ready = 1'b1;
    i_quantity = 16'd5;
    push(1'b0, NEW, 100, 5);
    push(1'b1, NEW, 110, 5);
    send_pair(100, 110);
    @(posedge clk); @(negedge clk);
    check("lat_t2_valid", {63'd0, o_order_valid}, 64'd0);
    @(posedge clk); @(negedge clk);
    check("lat_t3_valid_side", {62'd0, o_order_valid, o_order_side}, 64'b10);
    @(posedge clk); @(negedge clk);
    check("lat_t4_valid_side", {62'd0, o_order_valid, o_order_side}, 64'b11);
    @(posedge clk); @(negedge clk);
    check("lat_t5_valid", {63'd0, o_order_valid}, 64'd0);
    drain("drain_new");

    push(1'b0, REP, 101, 5);
    send_pair(101, 110);
    drain("drain_replace");

    send_pair(101, 110);
    drain("drain_same");

    push(1'b0, CAN, 0, 0);
    push(1'b1, CAN, 0, 0);
    send_pair(110, 105);
    drain("drain_cancel");

    send_pair(0, 0);
    drain("drain_zero");

    // Stall in SEND_BID while three more pairs arrive; only the last survives.
    i_order_ready = 1'b0;
    push(1'b0, NEW, 200, 5);
    push(1'b1, NEW, 210, 5);
    push(1'b0, REP, 203, 5);
    push(1'b1, REP, 213, 5);
    d0 = drops;
    send_pair(200, 210);
    wait_valid("stall_valid");
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      send_pair(200 + k, 210 + k);
    end
    check("stall_still_bid", {62'd0, o_order_valid, o_order_side}, 64'b10);
    @(posedge clk); #1;
    i_order_ready = 1'b1;
    drain("drain_stall");
    check("drop_count", 64'(drops - d0), 64'd2);

    // Ids 10..15 then wrap to 1, 2.
    for (int k = 4; k <= 7; k++) begin
      push(1'b0, REP, 200 + k, 5);
      push(1'b1, REP, 210 + k, 5);
      send_pair(200 + k, 210 + k);
      drain("drain_wrap");
    end

    // Reset while an order is presented.
    i_order_ready = 1'b0;
    send_pair(50, 60);
    wait_valid("pre_reset_valid");
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_zero("reset_mid_outputs");
    exp_q.delete();
    @(posedge clk); #1;
    i_reset = 1'b0;
    exp_id = IW'(1);
    i_order_ready = 1'b1;
    push(1'b0, NEW, 50, 5);
    push(1'b1, NEW, 60, 5);
    send_pair(50, 60);
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
